// File: rtl/pmod_input_debouncer.sv
// pmod_input_debouncer
//   Brings CH asynchronous Pmod/button pins into the CLK domain, debounces
//   each channel independently, and presents a clean registered level with
//   one-cycle rise/fall pulses. An 8-bit wrap-around counter tallies the
//   cycles in which at least one channel produced a rising edge.
//
//   Per-channel timing: a pin change that is stable before edge 1 appears
//   on level (with its rise/fall pulse) on edge SYNC_STAGES+DEB_LEN.
//   Shorter excursions restart the debounce count and never reach level.

module pmod_input_debouncer #(
    parameter int CH          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_LEN     = 60000
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [CH-1:0] pin_in,
    input  logic          cnt_clr,
    output logic [CH-1:0] level,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic [7:0]    rise_count
);

    // Counter only has to reach DEB_LEN-1, which always fits in clog2 bits.
    localparam int            DW       = $clog2(DEB_LEN);
    localparam logic [DW-1:0] CNT_ZERO = {DW{1'b0}};
    localparam logic [DW-1:0] CNT_ONE  = DW'(1);
    localparam logic [DW-1:0] CNT_TERM = DW'(DEB_LEN - 1);

    // Synchroniser chain: stage 0 takes the raw pins, last stage is trusted.
    logic [CH-1:0] sync_r [SYNC_STAGES];
    logic [CH-1:0] syn_s;

    // Debounce state and its next-state values.
    logic [DW-1:0] cnt_r     [CH];
    logic [DW-1:0] cnt_nxt_s [CH];
    logic [CH-1:0] level_nxt_s;
    logic [CH-1:0] rise_nxt_s;
    logic [CH-1:0] fall_nxt_s;

    // Rising-event tally next-state.
    logic [7:0]    rise_count_nxt_s;

    // Saturating-free 8-bit increment used by the event tally; wraps 255 -> 0.
    function automatic logic [7:0] inc8(input logic [7:0] value);
        return value + 8'd1;
    endfunction

    // Shift the raw pins through the synchroniser with no logic between stages.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_r[s] <= {CH{1'b0}};
            end
        end else begin
            sync_r[0] <= pin_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    assign syn_s = sync_r[SYNC_STAGES-1];

    // Per-channel debounce decision: count while the synced pin disagrees
    // with level, commit and pulse on the terminal count, restart otherwise.
    always_comb begin
        level_nxt_s = level;
        rise_nxt_s  = {CH{1'b0}};
        fall_nxt_s  = {CH{1'b0}};
        for (int i = 0; i < CH; i++) begin
            cnt_nxt_s[i] = CNT_ZERO;
            if (syn_s[i] == level[i]) begin
                cnt_nxt_s[i] = CNT_ZERO;
            end else if (cnt_r[i] == CNT_TERM) begin
                cnt_nxt_s[i]   = CNT_ZERO;
                level_nxt_s[i] = syn_s[i];
                rise_nxt_s[i]  = syn_s[i];
                fall_nxt_s[i]  = ~syn_s[i];
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
    end

    // Register debounce counters, level and the edge pulses together so the
    // pulses line up with the level change.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < CH; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
            level <= {CH{1'b0}};
            rise  <= {CH{1'b0}};
            fall  <= {CH{1'b0}};
        end else begin
            for (int i = 0; i < CH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            level <= level_nxt_s;
            rise  <= rise_nxt_s;
            fall  <= fall_nxt_s;
        end
    end

    // Event tally: clear has priority, otherwise count any cycle with a rise.
    always_comb begin
        rise_count_nxt_s = rise_count;
        if (cnt_clr) begin
            rise_count_nxt_s = 8'd0;
        end else if (|rise) begin
            rise_count_nxt_s = inc8(rise_count);
        end else begin
            rise_count_nxt_s = rise_count;
        end
    end

    // Register the event tally.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rise_count <= 8'd0;
        end else begin
            rise_count <= rise_count_nxt_s;
        end
    end

endmodule
